// File: rtl/gb_bus_pkg.sv
// Shared definitions for the Game Boy write-bus front end and its consumers.
package gb_bus_pkg;

   localparam int REC_W = 12;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOW  = 2'd1;
   localparam logic [1:0] ST_PUSH = 2'd2;

   localparam logic [3:0] RAMEN_0 = 4'h0;
   localparam logic [3:0] RAMEN_1 = 4'h1;
   localparam logic [3:0] ROMB_LO = 4'h2;
   localparam logic [3:0] ROMB_HI = 4'h3;
   localparam logic [3:0] RAMB_0  = 4'h4;
   localparam logic [3:0] RAMB_1  = 4'h5;
   localparam logic [3:0] GSEL    = 4'h7;

   function automatic logic [REC_W-1:0] pack_rec(input logic [3:0] addr, input logic [7:0] data);
      return {addr, data};
   endfunction

endpackage

// File: rtl/gb_wr_fifo.sv
// Small write-record FIFO; registered head, no fall-through.
module gb_wr_fifo #(
   parameter int W     = 12,
   parameter int DEPTH = 2
) (
   input  logic         CLK,
   input  logic         RST,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] wdata,
   output logic [W-1:0] rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wp;
   logic [AW:0]  rp;
   logic [W-1:0] mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign empty   = (wp == rp);
   assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
   assign do_pop  = pop & ~empty;
   // a full FIFO still accepts a push when the head leaves in the same cycle
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rp[AW-1:0]];

   // pointer and storage update
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wp <= '0;
         rp <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wp[AW-1:0]] <= wdata;
            wp              <= wp + 1'b1;
         end
         if (do_pop) rp <= rp + 1'b1;
      end
   end

endmodule

// File: rtl/gb_bus_sync.sv
// Game Boy write-bus synchroniser, WR glitch filter and record queue.
//
//  state | meaning
//  IDLE  | waiting for a synced falling edge of GB_WR (only once armed)
//  LOW   | GB_WR held low; counting low samples, shadow tracks A/D
//  PUSH  | qualified write; shadow record enqueued this cycle
module gb_bus_sync
   import gb_bus_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_LOW     = 3,
   parameter int FIFO_DEPTH  = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [3:0] GB_A,
   input  logic [7:0] GB_D,
   input  logic       GB_WR,
   input  logic       GB_RD,
   output logic       WR_VALID,
   input  logic       WR_READY,
   output logic [3:0] WR_ADDR,
   output logic [7:0] WR_DATA,
   output logic       RD_ACTIVE,
   output logic       OVF
);

   localparam int             BUS_W     = 15;
   localparam int             LW        = $clog2(MIN_LOW + 1);
   localparam logic [LW-1:0]  LOW_MAX   = LW'(MIN_LOW);
   // vld, wr, rd, a, d -- the vld bit is 0 in the preset so the reset values
   // are never mistaken for a real idle bus sample
   localparam logic [BUS_W-1:0] SYNC_INIT = {1'b0, 1'b1, 1'b1, 12'h000};

   logic [BUS_W-1:0] sync_q [SYNC_STAGES];
   logic             vld_s;
   logic             wr_s;
   logic             rd_s;
   logic [3:0]       a_s;
   logic [7:0]       d_s;

   logic [1:0]       state;
   logic [LW-1:0]    lowcnt;
   logic [REC_W-1:0] shadow;
   logic             armed;
   logic             push;
   logic             pop;
   logic             fifo_full;
   logic             fifo_empty;
   logic [REC_W-1:0] head;

   assign {vld_s, wr_s, rd_s, a_s, d_s} = sync_q[SYNC_STAGES-1];

   // one shared chain keeps strobe, address and data aligned
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_INIT;
      end else begin
         sync_q[0] <= {1'b1, GB_WR, GB_RD, GB_A, GB_D};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   // arming, read status and sticky overflow
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         armed     <= 1'b0;
         RD_ACTIVE <= 1'b0;
         OVF       <= 1'b0;
      end else begin
         armed     <= armed | (vld_s & wr_s);
         RD_ACTIVE <= ~rd_s;
         if (push && fifo_full && !pop) OVF <= 1'b1;
      end
   end

   // write qualification FSM; shadow holds the last low-phase sample
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state  <= ST_IDLE;
         lowcnt <= '0;
         shadow <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (armed && !wr_s) begin
                  state  <= ST_LOW;
                  lowcnt <= LW'(1);
                  shadow <= pack_rec(a_s, d_s);
               end
            end
            ST_LOW: begin
               if (!wr_s) begin
                  if (lowcnt < LOW_MAX) lowcnt <= lowcnt + 1'b1;
                  shadow <= pack_rec(a_s, d_s);
               end else if (lowcnt >= LOW_MAX) begin
                  state <= ST_PUSH;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_PUSH: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign push     = (state == ST_PUSH);
   assign pop      = WR_VALID & WR_READY;
   assign WR_VALID = ~fifo_empty;
   assign WR_ADDR  = head[REC_W-1:8];
   assign WR_DATA  = head[7:0];

   gb_wr_fifo #(
      .W     (REC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push),
      .pop   (pop),
      .wdata (shadow),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

endmodule

// File: tb/tb_gb_bus_sync.sv
// Scoreboard bench for gb_bus_sync: expected records queued at issue,
// compared by a monitor whenever a record is handed over.
module tb_gb_bus_sync;
   import gb_bus_pkg::*;

   logic       CLK = 1'b0;
   logic       RST;
   logic [3:0] GB_A;
   logic [7:0] GB_D;
   logic       GB_WR;
   logic       GB_RD;
   logic       WR_VALID;
   logic       WR_READY;
   logic [3:0] WR_ADDR;
   logic [7:0] WR_DATA;
   logic       RD_ACTIVE;
   logic       OVF;

   int         n_vec = 0;
   int         n_err = 0;
   logic [11:0] exp_q [$];

   gb_bus_sync #(
      .SYNC_STAGES (2),
      .MIN_LOW     (3),
      .FIFO_DEPTH  (2)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .GB_A      (GB_A),
      .GB_D      (GB_D),
      .GB_WR     (GB_WR),
      .GB_RD     (GB_RD),
      .WR_VALID  (WR_VALID),
      .WR_READY  (WR_READY),
      .WR_ADDR   (WR_ADDR),
      .WR_DATA   (WR_DATA),
      .RD_ACTIVE (RD_ACTIVE),
      .OVF       (OVF)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string nm, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // hold GB_WR low for n clock edges, then release it
   task automatic wr_low(input logic [3:0] a, input logic [7:0] d, input int n);
      GB_A  = a;
      GB_D  = d;
      GB_WR = 1'b0;
      repeat (n) tick();
      GB_WR = 1'b1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [7:0] d, input int n);
      wr_low(a, d, n);
      repeat (6) tick();
   endtask

   // monitor: a record leaves at the next edge whenever valid and ready are both high
   always @(negedge CLK) begin
      if (!RST && WR_VALID && WR_READY) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_record actual=%h required=none", {WR_ADDR, WR_DATA});
         end else begin
            check("record", int'({WR_ADDR, WR_DATA}), int'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      int n;
      int seen;
      RST = 1'b1; GB_A = 4'h0; GB_D = 8'h00; GB_WR = 1'b0; GB_RD = 1'b1; WR_READY = 1'b1;
      repeat (3) tick();
      check("rst_valid", WR_VALID, 0);
      check("rst_addr", WR_ADDR, 0);
      check("rst_data", WR_DATA, 0);
      check("rst_rd_active", RD_ACTIVE, 0);
      check("rst_ovf", OVF, 0);

      // 1: WR low across reset release must not produce a record
      GB_A = ROMB_HI; GB_D = 8'h5A;
      RST = 1'b0;
      seen = 0;
      repeat (8) begin tick(); if (WR_VALID) seen = 1; end
      GB_WR = 1'b1;
      repeat (8) begin tick(); if (WR_VALID) seen = 1; end
      check("t1_no_record", seen, 0);

      // RD status path
      GB_RD = 1'b0;
      repeat (4) tick();
      check("rd_active_on", RD_ACTIVE, 1);
      GB_RD = 1'b1;
      repeat (4) tick();
      check("rd_active_off", RD_ACTIVE, 0);

      // 2: basic write and end-to-end latency
      exp_q.push_back({ROMB_LO, 8'h05});
      wr_low(ROMB_LO, 8'h05, 6);
      n = 0;
      while (!WR_VALID && n < 20) begin tick(); n++; end
      check("t2_latency", n, 4);
      tick();
      check("t2_single_pulse", WR_VALID, 0);
      repeat (4) tick();

      // 3: glitch rejected, minimum-width write accepted
      wr(GSEL, 8'hEE, 2);
      check("t3_glitch_valid", WR_VALID, 0);
      check("t3_glitch_ovf", OVF, 0);
      exp_q.push_back({RAMEN_1, 8'h0A});
      wr(RAMEN_1, 8'h0A, 3);

      // 4: data changing mid-low-phase commits the last value
      exp_q.push_back({RAMB_0, 8'h22});
      GB_A = RAMB_0; GB_D = 8'h11; GB_WR = 1'b0;
      repeat (3) tick();
      GB_D = 8'h22;
      repeat (3) tick();
      GB_WR = 1'b1;
      repeat (6) tick();

      // 5: overflow with consumer stalled
      WR_READY = 1'b0;
      exp_q.push_back({RAMB_1, 8'hA1});
      wr(RAMB_1, 8'hA1, 4);
      exp_q.push_back({RAMB_1, 8'hA2});
      wr(RAMB_1, 8'hA2, 4);
      wr(RAMB_1, 8'hA3, 4);
      check("t5_ovf", OVF, 1);
      check("t5_valid", WR_VALID, 1);
      check("t5_head_data", WR_DATA, 8'hA1);
      repeat (3) tick();
      check("t5_head_stable", WR_DATA, 8'hA1);
      WR_READY = 1'b1;
      repeat (4) tick();
      WR_READY = 1'b0;
      check("t5_drained", WR_VALID, 0);
      check("t5_ovf_sticky", OVF, 1);
      check("t5_all_seen", exp_q.size(), 0);

      RST = 1'b1;
      repeat (2) tick();
      check("rst2_ovf", OVF, 0);
      RST = 1'b0;
      repeat (4) tick();

      // 6: push on full coincides with pop
      exp_q.push_back({ROMB_LO, 8'hB1});
      wr(ROMB_LO, 8'hB1, 4);
      exp_q.push_back({ROMB_LO, 8'hB2});
      wr(ROMB_LO, 8'hB2, 4);
      exp_q.push_back({ROMB_LO, 8'hB3});
      wr_low(ROMB_LO, 8'hB3, 4);
      repeat (3) tick();
      WR_READY = 1'b1;
      tick();
      WR_READY = 1'b0;
      repeat (2) tick();
      check("t6_ovf", OVF, 0);
      check("t6_valid", WR_VALID, 1);
      check("t6_head_b2", WR_DATA, 8'hB2);
      WR_READY = 1'b1;
      tick();
      WR_READY = 1'b0;
      check("t6_head_b3", WR_DATA, 8'hB3);
      RST = 1'b1;
      tick();
      check("t6_rst_valid", WR_VALID, 0);
      check("t6_rst_ovf", OVF, 0);
      exp_q.delete();
      RST = 1'b0;
      repeat (4) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
